router_ingress: RTL
===================

ROUTER_INGRESS -- requirements
Module: router_ingress

Interface
REQ-001 SHALL have no parameters; data width fixed at 8 bits, 3 destinations.
REQ-002 SHALL have port: clock  in  1  sole clock, all state on posedge.
REQ-003 SHALL have port: resetn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: data_in  in  8  packet byte from source.
REQ-005 SHALL have port: pkt_valid  in  1  high for header and payload bytes; low on parity byte.
REQ-006 SHALL have port: fifo_full  in  3  per-destination FIFO full flags.
REQ-007 SHALL have port: fifo_empty  in  3  per-destination FIFO empty flags.
REQ-008 SHALL have port: busy  out  1  source must hold data_in/pkt_valid stable while high.
REQ-009 SHALL have port: error  out  1  parity or length error on last packet.
REQ-010 SHALL have port: dout  out  8  byte to destination FIFO.
REQ-011 SHALL have port: write_enb  out  3  one-hot FIFO write strobe aligned with dout.

Function
REQ-012 Packet format SHALL be header {len[7:2], addr[1:0]}, len payload bytes (0..63), then one parity byte = XOR of header and all payload bytes.
REQ-013 FSM states SHALL be IDLE, WAIT_EMPTY, LOAD_DATA, FULL_HOLD, CHECK_PARITY, DROP.
REQ-014 IDLE: pkt_valid=1 and addr!=3 latches addr and len; fifo_empty[addr]=1 -> accept header, go LOAD_DATA; else -> WAIT_EMPTY.
REQ-015 IDLE with pkt_valid=0 SHALL ignore data_in and hold all outputs idle.
REQ-016 WAIT_EMPTY: busy=1; header not written; on fifo_empty[addr]=1 accept header from data_in, go LOAD_DATA.
REQ-017 Accepted byte SHALL appear on dout with write_enb[addr]=1 in the cycle after the accepting edge (1-cycle latency); write_enb SHALL be 0 in all other cycles.
REQ-018 LOAD_DATA: fifo_full[addr]=0 -> accept data_in each cycle, XOR into parity accumulator, increment 6-bit payload counter when pkt_valid=1.
REQ-019 LOAD_DATA: fifo_full[addr]=1 -> no byte accepted, go FULL_HOLD; busy=1 from that cycle.
REQ-020 FULL_HOLD: busy=1, no write; on fifo_full[addr]=0 return to LOAD_DATA, accept the held byte that cycle.
REQ-021 Byte accepted with pkt_valid=0 in LOAD_DATA SHALL be the parity byte: written to FIFO, not XORed into accumulator, go CHECK_PARITY.
REQ-022 Full flag and parity byte in same cycle SHALL hold the parity byte (REQ-019 precedence).
REQ-023 CHECK_PARITY: busy=1 for exactly one cycle; error<=1 if parity byte != accumulator or counter != len; go IDLE.
REQ-024 error SHALL stay stable until the next header is accepted, then clear to 0 on that edge.
REQ-025 addr=3 in IDLE SHALL go DROP: no writes, busy=0, error unchanged; discard bytes until the first pkt_valid=0 byte, then IDLE.
REQ-026 Payload counter SHALL not wrap beyond 63; count > 63 saturates and flags length error.
REQ-027 Back-to-back header SHALL be accepted no earlier than the cycle after CHECK_PARITY.

Reset
REQ-028 resetn=0 SHALL immediately force state IDLE, busy=0, error=0, dout=8'h00, write_enb=3'b000, counter/accumulator/addr cleared.
REQ-029 Reset mid-packet SHALL abandon the packet; remaining bytes before next header are not written once released in IDLE unless pkt_valid=1 header (source must restart).
REQ-030 Outputs SHALL change only on posedge clock after resetn deasserts; no combinational path from inputs to outputs.

Verification
REQ-031 Header 8'h0D, payload 11/22/33, parity 8'h0D, FIFO1 empty -> write_enb=3'b010 for 5 consecutive cycles, dout 0D,11,22,33,0D, busy 1 for one cycle, error=0.
REQ-032 Same packet with parity 8'hFF -> error=1 the cycle after CHECK_PARITY, held until next header accepted.
REQ-033 fifo_full[1]=1 for 3 cycles while 8'h22 presented -> busy=1, write_enb=0 for 3 cycles, 8'h22 written once after release, no byte lost/duplicated.
REQ-034 Header 8'h06 (addr 2) with fifo_empty[2]=0 for 4 cycles -> busy=1, no writes; header written on cycle after fifo_empty[2]=1.
REQ-035 Header 8'h07 (addr 3) plus 1 payload, parity -> write_enb stays 0, busy=0, FSM back in IDLE, next valid packet accepted normally.
REQ-036 resetn low during 2nd payload byte -> busy, error, write_enb, dout zero asynchronously; fresh packet after release delivered correctly.

Source files
------------

// File: rtl/router_ingress.sv
// ---------------------------------------------------------------------------
// router_ingress
//   Ingress stage of a 3-port packet router. It parses the header, steers
//   header, payload and parity bytes to the addressed destination FIFO with
//   one cycle of latency, and checks parity and length at the end of each
//   packet. Packets addressed to port 3 are swallowed without any writes.
//
//   Packet format: header {len[7:2], addr[1:0]}, len payload bytes, then a
//   parity byte equal to the XOR of the header and all payload bytes.
//
// Ports
//   clock       in   1  sole clock, all state updates on posedge
//   resetn      in   1  asynchronous active-low reset
//   data_in     in   8  packet byte from the source
//   pkt_valid   in   1  high for header/payload bytes, low on the parity byte
//   fifo_full   in   3  per-destination FIFO full flags
//   fifo_empty  in   3  per-destination FIFO empty flags
//   busy        out  1  source must hold data_in/pkt_valid while high
//   error       out  1  parity or length error on the last packet
//   dout        out  8  byte to the destination FIFO
//   write_enb   out  3  one-hot FIFO write strobe aligned with dout
// ---------------------------------------------------------------------------
module router_ingress (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] data_in,
  input  logic       pkt_valid,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  output logic       busy,
  output logic       error,
  output logic [7:0] dout,
  output logic [2:0] write_enb
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EMPTY,
    LOAD_DATA,
    FULL_HOLD,
    CHECK_PARITY,
    DROP
  } state_t;

  state_t     state;
  state_t     next_state;

  logic [1:0] addr_q;
  logic [5:0] len_q;
  logic [5:0] cnt_q;
  logic       len_err_q;
  logic [7:0] acc_q;
  logic [7:0] parity_q;

  // Flags widened to four entries so a 2-bit address can index them
  // directly; entry 3 belongs to the drop port and is never consulted.
  logic [3:0] empty_ext;
  logic [3:0] full_ext;
  logic [1:0] hdr_addr;
  logic       hdr_accept;
  logic       byte_accept;
  logic [1:0] wr_addr;

  assign empty_ext = {1'b0, fifo_empty};
  assign full_ext  = {1'b0, fifo_full};
  assign hdr_addr  = data_in[1:0];

  // A header is taken either straight from IDLE or after waiting for the
  // destination FIFO to drain; payload and parity bytes are taken whenever
  // the destination FIFO has room.
  assign hdr_accept = ((state == IDLE) && pkt_valid && (hdr_addr != 2'd3) &&
                       empty_ext[hdr_addr]) ||
                      ((state == WAIT_EMPTY) && empty_ext[addr_q]);
  assign byte_accept = ((state == LOAD_DATA) || (state == FULL_HOLD)) &&
                       !full_ext[addr_q];
  assign wr_addr = (state == IDLE) ? hdr_addr : addr_q;

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A full flag always wins over the parity byte, so a
  // parity byte presented against a full FIFO is held like any other byte.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (pkt_valid) begin
          if (hdr_addr == 2'd3)            next_state = DROP;
          else if (empty_ext[hdr_addr])    next_state = LOAD_DATA;
          else                             next_state = WAIT_EMPTY;
        end
      end
      WAIT_EMPTY: begin
        if (empty_ext[addr_q]) next_state = LOAD_DATA;
      end
      LOAD_DATA, FULL_HOLD: begin
        if (full_ext[addr_q]) next_state = FULL_HOLD;
        else if (!pkt_valid)  next_state = CHECK_PARITY;
        else                  next_state = LOAD_DATA;
      end
      CHECK_PARITY: next_state = IDLE;
      DROP: begin
        if (!pkt_valid) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Busy decodes from the state register only, so it never follows inputs
  // combinationally.
  always_comb begin
    busy = 1'b0;
    case (state)
      WAIT_EMPTY, FULL_HOLD, CHECK_PARITY: busy = 1'b1;
      default:                             busy = 1'b0;
    endcase
  end

  // Datapath: write strobe, parity accumulator, payload counter and the
  // end-of-packet error flag. The counter saturates at 63 and remembers the
  // overflow so an over-long packet can never alias to a legal length.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dout      <= 8'h00;
      write_enb <= 3'b000;
      error     <= 1'b0;
      addr_q    <= 2'd0;
      len_q     <= 6'd0;
      cnt_q     <= 6'd0;
      len_err_q <= 1'b0;
      acc_q     <= 8'h00;
      parity_q  <= 8'h00;
    end else begin
      write_enb <= 3'b000;
      if (hdr_accept || byte_accept) begin
        dout      <= data_in;
        write_enb <= 3'b001 << wr_addr;
      end
      if ((state == IDLE) && pkt_valid && (hdr_addr != 2'd3)) begin
        addr_q <= hdr_addr;
        len_q  <= data_in[7:2];
      end
      if (hdr_accept) begin
        acc_q     <= data_in;
        cnt_q     <= 6'd0;
        len_err_q <= 1'b0;
        error     <= 1'b0;
      end
      if (byte_accept) begin
        if (pkt_valid) begin
          acc_q <= acc_q ^ data_in;
          if (cnt_q == 6'd63) len_err_q <= 1'b1;
          else                cnt_q     <= cnt_q + 6'd1;
        end else begin
          parity_q <= data_in;
        end
      end
      if (state == CHECK_PARITY) begin
        error <= (parity_q != acc_q) || (cnt_q != len_q) || len_err_q;
      end
    end
  end

endmodule
